n64_vinfo_ext: RTL and testbench



---
 rtl/n64_vinfo_ext.sv | 113 +++++++++++
 tb/tb_n64_vinfo_ext.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vinfo_ext.sv
// n64_vinfo_ext: RGB phase counter and per-frame video info extraction.
// It watches the N64 nCLK/nDSYNC/D_i bus just ahead of the video demux.
// All logic runs on the falling edge of nCLK.
// Optional feature macro: VINFO_SYNC_LOSS_EN. When it is defined, a line
// counter that stays saturated (VSYNC lost) drops the qualified video info.
module n64_vinfo_ext #(
  parameter int LINE_CNT_W  = 10,
  parameter int PAL_LINE_TH = 288
) (
  input  logic       nCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [6:0] D_i,
  output logic [1:0] data_cnt_o,
  output logic       nvsync_fall_o,
  output logic       vmode_o,
  output logic       n64_480i_o,
  output logic       vinfo_valid_o
);

  localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_CNT_W-1:0] LINE_ONE = LINE_CNT_W'(1);
  localparam logic [LINE_CNT_W-1:0] PAL_TH   = LINE_CNT_W'(PAL_LINE_TH);

  logic                  nvsync_prev;
  logic                  nhsync_prev;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LINE_CNT_W-1:0] prev_field_cnt;
  logic                  field_seen;

  logic vsync_edge;
  logic hsync_edge;
  logic line_sat;
  logic sync_loss;

  // Only nVSYNC (bit 3) and nHSYNC (bit 1) drive decisions; the rest of
  // the bus is intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{D_i[6:4], D_i[2], D_i[0]};

  // Sync edges are only meaningful in sync cycles (nDSYNC low).
  assign vsync_edge = ~nDSYNC & nvsync_prev & ~D_i[3];
  assign hsync_edge = ~nDSYNC & nhsync_prev & ~D_i[1];
  assign line_sat   = (line_cnt == LINE_MAX);

`ifdef VINFO_SYNC_LOSS_EN
  // A saturated line counter means VSYNC went missing: drop the qualified
  // info, unless a VSYNC edge in this very cycle starts a new field.
  assign sync_loss = line_sat & ~vsync_edge;
`else
  // Without sync-loss handling a saturated counter just holds.
  assign sync_loss = 1'b0;
`endif

  // RGB phase: a sync cycle arms red for the next cycle, then green, blue, idle.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      data_cnt_o <= 2'd0;
    end else if (!nDSYNC) begin
      data_cnt_o <= 2'd1;
    end else if (data_cnt_o != 2'd0) begin
      data_cnt_o <= data_cnt_o + 2'd1;
    end
  end

  // Sync history, sampled only in sync cycles.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      nvsync_prev <= 1'b1;
      nhsync_prev <= 1'b1;
    end else if (!nDSYNC) begin
      nvsync_prev <= D_i[3];
      nhsync_prev <= D_i[1];
    end
  end

  // Line counting per field; an HSYNC edge coinciding with VSYNC belongs to the new field.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      line_cnt       <= '0;
      prev_field_cnt <= '0;
    end else if (vsync_edge) begin
      prev_field_cnt <= line_cnt;
      line_cnt       <= hsync_edge ? LINE_ONE : '0;
    end else if (hsync_edge && !line_sat) begin
      line_cnt <= line_cnt + LINE_ONE;
    end
  end

  // Video info updates once per field at the VSYNC edge; the first field only sets vmode.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      nvsync_fall_o <= 1'b0;
      vmode_o       <= 1'b0;
      n64_480i_o    <= 1'b0;
      vinfo_valid_o <= 1'b0;
      field_seen    <= 1'b0;
    end else begin
      nvsync_fall_o <= vsync_edge;
      if (vsync_edge) begin
        vmode_o       <= (line_cnt >= PAL_TH);
        n64_480i_o    <= field_seen & (line_cnt != prev_field_cnt);
        vinfo_valid_o <= field_seen;
        field_seen    <= 1'b1;
      end else if (sync_loss) begin
        n64_480i_o    <= 1'b0;
        vinfo_valid_o <= 1'b0;
        field_seen    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// Testbench for n64_vinfo_ext: directed sequence with randomized bus filler,
// compared each cycle against a field-history reference model.
module tb_n64_vinfo_ext;

  localparam int LINE_MAX = 1023;
  localparam int PAL_TH   = 288;

  logic       nCLK;
  logic       nRST;
  logic       nDSYNC;
  logic [6:0] D_i;
  logic [1:0] data_cnt_o;
  logic       nvsync_fall_o;
  logic       vmode_o;
  logic       n64_480i_o;
  logic       vinfo_valid_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state: field lengths seen, lines in the current field,
  // last sampled sync levels, cycles since the last sync cycle.
  int   fields[$];
  int   cur_lines;
  int   since_sync;
  logic last_v;
  logic last_h;
  logic exp_vmode;
  logic exp_pulse;

  n64_vinfo_ext dut (
    .nCLK          (nCLK),
    .nRST          (nRST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .data_cnt_o    (data_cnt_o),
    .nvsync_fall_o (nvsync_fall_o),
    .vmode_o       (vmode_o),
    .n64_480i_o    (n64_480i_o),
    .vinfo_valid_o (vinfo_valid_o)
  );

  // Clock: falling edge is the active edge; the bench works on rising edges.
  initial begin
    nCLK = 1'b0;
    forever #5 nCLK = ~nCLK;
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fields.delete();
    cur_lines  = 0;
    since_sync = 99;
    last_v     = 1'b1;
    last_h     = 1'b1;
    exp_vmode  = 1'b0;
    exp_pulse  = 1'b0;
  endtask

  // One nCLK cycle of the video-info rules, expressed on field lengths.
  task automatic model_step(input logic ds, input logic [6:0] d);
    logic v_edge;
    logic h_edge;
    v_edge = 1'b0;
    h_edge = 1'b0;
    if (!ds) begin
      v_edge = last_v && !d[3];
      h_edge = last_h && !d[1];
      last_v = d[3];
      last_h = d[1];
      since_sync = 0;
    end else if (since_sync < 99) begin
      since_sync++;
    end
`ifdef VINFO_SYNC_LOSS_EN
    if (cur_lines == LINE_MAX && !v_edge) fields.delete();
`endif
    exp_pulse = v_edge;
    if (v_edge) begin
      fields.push_back(cur_lines);
      if (fields.size() > 2) void'(fields.pop_front());
      exp_vmode = (cur_lines >= PAL_TH);
      cur_lines = h_edge ? 1 : 0;
    end else if (h_edge && cur_lines < LINE_MAX) begin
      cur_lines++;
    end
  endtask

  task automatic check_all();
    logic [1:0] exp_dcnt;
    logic       exp_valid;
    logic       exp_480i;
    exp_dcnt  = (since_sync < 3) ? 2'(since_sync + 1) : 2'd0;
    exp_valid = (fields.size() >= 2);
    exp_480i  = exp_valid && (fields[0] != fields[1]);
    chk("data_cnt", data_cnt_o, exp_dcnt);
    chk("nvsync_fall", {1'b0, nvsync_fall_o}, {1'b0, exp_pulse});
    chk("vmode", {1'b0, vmode_o}, {1'b0, exp_vmode});
    chk("n64_480i", {1'b0, n64_480i_o}, {1'b0, exp_480i});
    chk("vinfo_valid", {1'b0, vinfo_valid_o}, {1'b0, exp_valid});
    if (nvsync_fall_o) pulses++;
  endtask

  // Driver: called just after a rising edge; DUT samples on the falling edge.
  task automatic cyc(input logic ds, input logic [6:0] d);
    nDSYNC = ds;
    D_i    = d;
    @(negedge nCLK);
    model_step(ds, d);
    @(posedge nCLK);
    check_all();
  endtask

  task automatic sync_cyc(input logic v, input logic h);
    logic [6:0] d;
    d    = 7'($urandom);
    d[3] = v;
    d[1] = h;
    cyc(1'b0, d);
  endtask

  task automatic data_cycs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 7'($urandom));
  endtask

  task automatic line(input logic v);
    sync_cyc(v, 1'b0);
    data_cycs(int'($urandom_range(0, 3)));
    sync_cyc(v, 1'b1);
    data_cycs(int'($urandom_range(0, 3)));
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(1'b1);
  endtask

  // A field opens with a VSYNC+HSYNC line and has n lines in total.
  task automatic field(input int n);
    line(1'b0);
    lines(n - 1);
  endtask

  initial begin
    nRST   = 1'b0;
    nDSYNC = 1'b1;
    D_i    = 7'h7F;
    model_reset();
    repeat (3) @(posedge nCLK);
    check_all();
    nRST = 1'b1;

    // Phase counter: low,high,high,high repeated.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 7'h7F);
      data_cycs(3);
    end
    // Single sync then idle, then resync while green.
    cyc(1'b0, 7'h7F);
    data_cycs(6);
    chk("dcnt_idle", data_cnt_o, 2'd0);
    cyc(1'b0, 7'h7F);
    cyc(1'b1, 7'h00);
    chk("dcnt_green", data_cnt_o, 2'd2);
    cyc(1'b0, 7'h7F);
    chk("dcnt_resync", data_cnt_o, 2'd1);
    data_cycs(3);

    // NTSC: lead-in of 263 lines, then three 263-line fields.
    pulses = 0;
    lines(263);
    field(263);
    chk("ntsc_first_valid", {1'b0, vinfo_valid_o}, 2'd0);
    field(263);
    field(263);
    chk("ntsc_pulses", 2'(pulses), 2'd3);
    chk("ntsc_vmode", {1'b0, vmode_o}, 2'd0);
    chk("ntsc_valid", {1'b0, vinfo_valid_o}, 2'd1);
    chk("ntsc_480i", {1'b0, n64_480i_o}, 2'd0);

    // PAL interlaced: alternating 312/313, then constant 313.
    field(312);
    field(313);
    field(312);
    field(313);
    chk("pal_vmode", {1'b0, vmode_o}, 2'd1);
    chk("pal_480i", {1'b0, n64_480i_o}, 2'd1);
    field(313);
    field(313);
    chk("pal_prog_480i", {1'b0, n64_480i_o}, 2'd0);
    chk("pal_prog_valid", {1'b0, vinfo_valid_o}, 2'd1);

    // VSYNC lost while HSYNC keeps running: counter saturates.
    lines(1030);
`ifdef VINFO_SYNC_LOSS_EN
    chk("loss_valid", {1'b0, vinfo_valid_o}, 2'd0);
    chk("loss_vmode_hold", {1'b0, vmode_o}, 2'd1);
`else
    chk("hold_valid", {1'b0, vinfo_valid_o}, 2'd1);
    chk("hold_vmode", {1'b0, vmode_o}, 2'd1);
`endif
    field(263);
    field(263);
    field(263);
    chk("recover_valid", {1'b0, vinfo_valid_o}, 2'd1);
    chk("recover_vmode", {1'b0, vmode_o}, 2'd0);

    // Asynchronous reset in the middle of a field.
    lines(100);
    #2 nRST = 1'b0;
    #1;
    chk("arst_dcnt", data_cnt_o, 2'd0);
    chk("arst_pulse", {1'b0, nvsync_fall_o}, 2'd0);
    chk("arst_vmode", {1'b0, vmode_o}, 2'd0);
    chk("arst_480i", {1'b0, n64_480i_o}, 2'd0);
    chk("arst_valid", {1'b0, vinfo_valid_o}, 2'd0);
    model_reset();
    @(posedge nCLK);
    @(posedge nCLK);
    nRST = 1'b1;
    lines(50);
    field(313);
    chk("post_rst_valid", {1'b0, vinfo_valid_o}, 2'd0);
    field(313);
    chk("post_rst_valid2", {1'b0, vinfo_valid_o}, 2'd1);
    chk("post_rst_vmode", {1'b0, vmode_o}, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
